// File: rtl/pattern_sequencer.sv
// pattern_sequencer: walks a writable table of DEPTH output patterns at a
// programmable rate and drives the selected pattern onto a WIDTH-bit bus.
// Supports forward/reverse stepping, run-time sequence length, pause via
// en, and live table rewrite with write-through to the displayed entry.
// Optional feature macro: PATSEQ_ONESHOT_EN adds the oneshot input and the
// sticky done output; with it undefined the sequence always wraps.
module pattern_sequencer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 6,
   parameter int IDX_W = 3,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic [IDX_W-1:0] step_len,
   input  logic [DIV_W-1:0] div,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
`ifdef PATSEQ_ONESHOT_EN
   input  logic             oneshot,
   output logic             done,
`endif
   output logic [WIDTH-1:0] out,
   output logic [IDX_W-1:0] step_idx,
   output logic             wrap
);

   // Length arithmetic is one bit wider so DEPTH == 2^IDX_W is representable.
   localparam logic [IDX_W:0]   DEPTH_C   = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0]   LEN_ONE_C = (IDX_W+1)'(1);
   localparam logic [IDX_W-1:0] IDX_ONE_C = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_ZERO_C = IDX_W'(0);
   localparam logic [DIV_W-1:0] DIV_ONE_C = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_ZERO_C = DIV_W'(0);

   // Power-on pattern for table entry i, truncated or zero-extended to WIDTH.
   function automatic logic [WIDTH-1:0] init_entry(input int unsigned i);
      logic [7:0] b;
      case (i)
         32'd0:   b = 8'h90;
         32'd1:   b = 8'h18;
         32'd2:   b = 8'h48;
         32'd3:   b = 8'h60;
         32'd4:   b = 8'h24;
         32'd5:   b = 8'h84;
         default: b = 8'h00;
      endcase
      return WIDTH'(b);
   endfunction

   logic [WIDTH-1:0] table_r [0:DEPTH-1];
   logic [DIV_W-1:0] pre_r;
   logic [IDX_W-1:0] idx_r;
   logic [WIDTH-1:0] out_r;
   logic             wrap_r;

   logic             tick_s;
   logic [IDX_W:0]   len_ext_s;
   logic [IDX_W:0]   eff_len_s;
   logic [IDX_W-1:0] last_s;
   logic [IDX_W-1:0] next_idx_s;
   logic             next_wrap_s;
   logic             wrap_evt_s;
   logic [IDX_W-1:0] step_idx_s;
   logic [WIDTH-1:0] next_out_s;

`ifdef PATSEQ_ONESHOT_EN
   logic             done_r;
   logic             next_done_s;
`endif

   assign tick_s    = en && (pre_r == div);
   assign len_ext_s = {1'b0, step_len};

   // Clamp the live length to 1..DEPTH and derive the last active index.
   always_comb begin
      eff_len_s = len_ext_s;
      if (len_ext_s == {(IDX_W+1){1'b0}}) begin
         eff_len_s = LEN_ONE_C;
      end else if (len_ext_s > DEPTH_C) begin
         eff_len_s = DEPTH_C;
      end else begin
         eff_len_s = len_ext_s;
      end
      last_s = IDX_W'(eff_len_s - LEN_ONE_C);
   end

   // Candidate next index for a tick, flagging when the sequence wraps.
   always_comb begin
      step_idx_s = idx_r;
      wrap_evt_s = 1'b0;
      if (dir == 1'b0) begin
         if (idx_r < last_s) begin
            step_idx_s = idx_r + IDX_ONE_C;
         end else begin
            step_idx_s = IDX_ZERO_C;
            wrap_evt_s = 1'b1;
         end
      end else begin
         if ((idx_r == IDX_ZERO_C) || (idx_r > last_s)) begin
            step_idx_s = last_s;
            wrap_evt_s = 1'b1;
         end else begin
            step_idx_s = idx_r - IDX_ONE_C;
         end
      end
   end

   // Select the index and wrap pulse for the coming edge.
   always_comb begin
      next_idx_s  = idx_r;
      next_wrap_s = 1'b0;
`ifdef PATSEQ_ONESHOT_EN
      next_done_s = 1'b0;
      if (oneshot) begin
         if (done_r) begin
            // Finished one-shot run: ticks are ignored until oneshot drops.
            next_idx_s  = idx_r;
            next_done_s = 1'b1;
         end else if (tick_s && wrap_evt_s) begin
            // Park on the final step instead of wrapping.
            next_idx_s  = idx_r;
            next_done_s = 1'b1;
         end else if (tick_s) begin
            next_idx_s  = step_idx_s;
         end else begin
            next_idx_s  = idx_r;
         end
      end else if (tick_s) begin
         next_idx_s  = step_idx_s;
         next_wrap_s = wrap_evt_s;
      end else begin
         next_idx_s  = idx_r;
      end
`else
      if (tick_s) begin
         next_idx_s  = step_idx_s;
         next_wrap_s = wrap_evt_s;
      end else begin
         next_idx_s  = idx_r;
      end
`endif
   end

   // Write-through: a write landing on the entry about to be shown wins.
   always_comb begin
      if (wr_en && (wr_addr == next_idx_s)) begin
         next_out_s = wr_data;
      end else begin
         next_out_s = table_r[next_idx_s];
      end
   end

   // Prescaler: counts enabled cycles and restarts when a tick fires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_r <= DIV_ZERO_C;
      end else if (en) begin
         if (pre_r == div) begin
            pre_r <= DIV_ZERO_C;
         end else begin
            pre_r <= pre_r + DIV_ONE_C;
         end
      end
   end

   // Pattern table: reset restores the default patterns, writes land on the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            table_r[i] <= init_entry(i);
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == IDX_W'(i))) begin
               table_r[i] <= wr_data;
            end
         end
      end
   end

   // Registered outputs: index, displayed pattern and wrap pulse move together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_r  <= IDX_ZERO_C;
         out_r  <= init_entry(0);
         wrap_r <= 1'b0;
      end else begin
         idx_r  <= next_idx_s;
         out_r  <= next_out_s;
         wrap_r <= next_wrap_s;
      end
   end

`ifdef PATSEQ_ONESHOT_EN
   // Sticky one-shot completion flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_r <= 1'b0;
      end else begin
         done_r <= next_done_s;
      end
   end

   assign done = done_r;
`endif

   assign out      = out_r;
   assign step_idx = idx_r;
   assign wrap     = wrap_r;

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Parametrised step-pattern sequencer: walks a writable table of DEPTH output patterns at a programmable rate and drives the selected pattern onto a WIDTH-bit output bus. Supports forward/reverse stepping, a run-time sequence length, pause, and live table rewrite. Sits directly behind the top-level pin wrapper, with `out` routed to the dedicated outputs and the control fields taken from the input pins or a register block.

## Interface
- WIDTH, 8, pattern/output width in bits
- DEPTH, 6, number of table entries (2..2^IDX_W)
- IDX_W, 3, width of step index, length and write address
- DIV_W, 8, prescaler width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  1  run enable; low pauses prescaler and stepping
- dir  in  1  0 = forward (index up), 1 = reverse (index down)
- step_len  in  IDX_W  active steps L; 0 is treated as 1, values > DEPTH as DEPTH
- div  in  DIV_W  prescaler reload; one step every div+1 enabled cycles
- wr_en  in  1  table write strobe
- wr_addr  in  IDX_W  table write address; addresses >= DEPTH ignored
- wr_data  in  WIDTH  table write data
- out  out  WIDTH  registered current pattern
- step_idx  out  IDX_W  registered current index
- wrap  out  1  one-cycle pulse on sequence wrap

## Operation
- Reset: step_idx=0, prescaler=0, wrap=0, table[0..5]=0x90,0x18,0x48,0x60,0x24,0x84 (entries beyond 5 = 0; low WIDTH bits if WIDTH<8, zero-extended if WIDTH>8), out=table[0].
- Prescaler: when en=1 and pre==div, tick fires and pre returns to 0; else when en=1, pre increments; en=0 holds pre.
- Last index M = effective L − 1, evaluated every cycle from live step_len.
- On tick, forward: idx==M -> 0 with wrap; idx<M -> idx+1; idx>M (length shrunk) -> 0 with wrap.
- On tick, reverse: idx==0 -> M with wrap; idx>M -> M with wrap; otherwise idx−1.
- No tick: idx holds, wrap=0.
- dir and step_len changes take effect on the next tick; no reset of prescaler.
- Table write: wr_en=1 with wr_addr<DEPTH writes the entry at the clock edge.
- out is registered every cycle from next index: out <= (wr_en && wr_addr==next_idx) ? wr_data : table[next_idx]; write-through, so writes to the displayed entry appear one cycle later even without a tick.

## Timing
- step_idx, out and wrap update on the same edge; out always equals table[step_idx] as of that edge.
- div=0, en=1: one step per cycle. Latency from tick to visible out: 0 extra cycles (registered together).
- First tick after reset/en rise occurs after div+1 enabled cycles.
- reset asserted mid-sequence: all state returns to reset values immediately (async), including table contents; first step after release needs div+1 enabled cycles.
- Simultaneous write to an entry and step onto that entry: new wr_data is output.

## Configuration
- PATSEQ_ONESHOT_EN defined: adds input `oneshot` (1) and output `done` (1, reset 0). With oneshot=1, a tick that would wrap instead holds idx at its final step, sets done=1 (sticky), suppresses wrap, and ignores further ticks. oneshot=0 clears done on the next edge and normal stepping resumes on the next tick.
- Not defined: ports absent; sequence always wraps.

## Test plan
- Reset: assert reset mid-run -> out=0x90, step_idx=0, wrap=0 asynchronously; table write at entry 2 lost after reset (reads 0x48).
- Forward, div=0, L=6, en=1: out 0x18,0x48,0x60,0x24,0x84,0x90 on six consecutive edges; wrap high only on the 0x90 edge.
- div=2, en dropped 2 cycles after second enabled cycle: steps only every 3 enabled cycles; idx frozen while en=0.
- Reverse, L=4, from idx 0: idx 3 (0x60, wrap=1), 2, 1, 0; then set L=2 at idx 3 forward -> next tick idx 0 with wrap.
- Writes: wr_addr=1, wr_data=0xAA on tick from idx 0 -> out=0xAA; wr_addr=7 -> no change; write to current idx without tick -> out updates next cycle.
- PATSEQ_ONESHOT_EN, oneshot=1, L=3, div=0: idx 1,2 then holds at 2 (0x48), done=1, wrap never pulses; drop oneshot -> done=0, next tick idx 0 with wrap.
